// File: rtl/neuron_weight_reader.sv
// rtl/neuron_weight_reader.sv - streams one neuron's weights from BRAM and accumulates them against activations
//
// Purpose: on START, walks weight addresses 0..N_WEIGHTS-1 of a falling-edge
// BRAM in lock-step with an activation stream, multiply-accumulates signed
// Q8.8 products and returns one saturated Q8.8 pre-activation sum.
//
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   START                 one-cycle request, honoured only while idle
//   X_DATA/X_VALID/X_READY activation stream (signed Q8.8)
//   BRAM_ADDR/EN/WE/DI    read-only BRAM port (WE and DI tied to zero)
//   BRAM_DO               weight word, updated on the falling edge after an enabled read
//   SUM_OUT/SUM_VALID/SUM_READY  result handshake, result held until accepted
//   SAT                   result was clipped (qualified by SUM_VALID)
//   BUSY                  evaluation in progress
module neuron_weight_reader #(
  parameter int N_WEIGHTS = 30,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] X_DATA,
  input  logic              X_VALID,
  output logic              X_READY,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  output logic [DATA_W-1:0] BRAM_DI,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] SUM_OUT,
  output logic              SUM_VALID,
  input  logic              SUM_READY,
  output logic              SAT,
  output logic              BUSY
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0]       LAST_K  = ADDR_W'(N_WEIGHTS - 1);
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SUM_MIN = ~SUM_MAX;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]       k_q, k_d;
  logic                    x_ready_q, x_ready_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    en_q, en_d;
  logic [DATA_W-1:0]       sum_q, sum_d;
  logic                    sum_valid_q, sum_valid_d;
  logic                    sat_q, sat_d;
  logic                    busy_q, busy_d;

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    product_ext;
  logic signed [ACC_W-1:0]    scaled;

  // Operands are widened (sign-preserving) before the multiply so the full
  // 2*DATA_W product is formed, then sign-extended into the accumulator.
  assign product     = (2*DATA_W)'($signed(BRAM_DO)) * (2*DATA_W)'($signed(X_DATA));
  assign product_ext = ACC_W'(product);
  // Arithmetic shift rounds toward -inf, which is the intended truncation.
  assign scaled      = acc_q >>> FRAC_BITS;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    x_ready_d   = 1'b0;
    addr_d      = addr_q;
    en_d        = 1'b0;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    sat_d       = sat_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = PRIME;
          acc_d   = '0;
          k_d     = '0;
          addr_d  = '0;
          en_d    = 1'b1;
        end
      end
      PRIME: begin
        // Word 0 is captured on this cycle's falling edge.
        state_d   = RUN;
        x_ready_d = 1'b1;
      end
      RUN: begin
        x_ready_d = x_ready_q;
        if (X_VALID && x_ready_q) begin
          acc_d = acc_q + product_ext;
          if (k_q == LAST_K) begin
            x_ready_d = 1'b0;
            state_d   = DONE;
          end else begin
            // Fetch the next weight; it lands on the falling edge, in time
            // for the next rising edge, giving one sample per cycle.
            k_d    = k_q + 1'b1;
            addr_d = k_q + 1'b1;
            en_d   = 1'b1;
          end
        end
      end
      DONE: begin
        if (!sum_valid_q) begin
          sum_valid_d = 1'b1;
          if (scaled > SUM_MAX) begin
            sum_d = {1'b0, {(DATA_W-1){1'b1}}};
            sat_d = 1'b1;
          end else if (scaled < SUM_MIN) begin
            sum_d = {1'b1, {(DATA_W-1){1'b0}}};
            sat_d = 1'b1;
          end else begin
            sum_d = scaled[DATA_W-1:0];
            sat_d = 1'b0;
          end
        end else if (SUM_READY) begin
          sum_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      x_ready_q   <= 1'b0;
      addr_q      <= '0;
      en_q        <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      x_ready_q   <= x_ready_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
    end
  end

  assign X_READY   = x_ready_q;
  assign BRAM_ADDR = addr_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WE   = 1'b0;
  assign BRAM_DI   = '0;
  assign SUM_OUT   = sum_q;
  assign SUM_VALID = sum_valid_q;
  assign SAT       = sat_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_neuron_weight_reader.sv
// tb/tb_neuron_weight_reader.sv - self-checking bench for neuron_weight_reader
module tb_neuron_weight_reader;

  localparam int NW = 30;

  logic        CLK, RST_N, START, X_VALID, X_READY, BRAM_EN, BRAM_WE;
  logic        SUM_VALID, SUM_READY, SAT, BUSY;
  logic [15:0] X_DATA, BRAM_DI, BRAM_DO, SUM_OUT;
  logic [4:0]  BRAM_ADDR;

  neuron_weight_reader dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .X_DATA(X_DATA), .X_VALID(X_VALID), .X_READY(X_READY),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_DI(BRAM_DI),
    .BRAM_DO(BRAM_DO),
    .SUM_OUT(SUM_OUT), .SUM_VALID(SUM_VALID), .SUM_READY(SUM_READY),
    .SAT(SAT), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Falling-edge read-only BRAM.
  logic [15:0] mem [0:31];
  always @(negedge CLK) if (BRAM_EN && !BRAM_WE) BRAM_DO <= mem[BRAM_ADDR];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result from the accumulated real-valued sum: floor(acc/256), clipped to Q8.8.
  function automatic void model_result(input longint a, output logic [15:0] s, output logic st);
    longint r;
    r = a / 256;
    if ((a % 256) != 0 && a < 0) r = r - 1;
    if (r > 32767)       begin s = 16'h7FFF; st = 1'b1; end
    else if (r < -32768) begin s = 16'h8000; st = 1'b1; end
    else                 begin s = r[15:0];  st = 1'b0; end
  endfunction

  // Behavioural model state.
  int          cyc = 0, start_cyc = 0, lat = 0, n_results = 0;
  int          m_k = 0, dcnt = 0;
  longint      m_acc = 0;
  bit          m_active = 0, prev_start = 0, prev_hs = 0, hold_prev = 0;
  logic [15:0] prev_sum, res_sum, mres_sum;
  logic        prev_sat, res_sat, mres_sat;
  int          reads [0:31];

  always begin : compare
    logic [15:0] es;
    logic        esat, exp_valid, en_exp, hs, ps;
    @(negedge CLK); #2;
    cyc++;
    if (!RST_N) begin
      m_active = 0; m_k = 0; m_acc = 0; dcnt = 0;
      prev_start = 0; prev_hs = 0; hold_prev = 0;
    end else begin
      exp_valid = m_active && (m_k == NW) && (dcnt >= 1);
      chk("bram_we", BRAM_WE, 0);
      chk("bram_di", BRAM_DI, 0);
      chk("busy", BUSY, m_active);
      chk("x_ready", X_READY, m_active && !prev_start && (m_k < NW));
      en_exp = prev_start || (prev_hs && m_k < NW);
      chk("bram_en", BRAM_EN, en_exp);
      if (BRAM_EN) begin
        chk("bram_addr", BRAM_ADDR, m_k);
        if (m_k < 32) reads[m_k]++;
      end
      if (X_READY && m_k < NW) chk("weight_pair", BRAM_DO, mem[m_k]);
      chk("sum_valid", SUM_VALID, exp_valid);
      if (exp_valid) begin
        model_result(m_acc, es, esat);
        chk("sum_out", SUM_OUT, es);
        chk("sat", SAT, esat);
        if (dcnt == 1) lat = cyc - start_cyc - 1;
      end
      if (hold_prev) begin
        chk("hold_sum", SUM_OUT, prev_sum);
        chk("hold_sat", SAT, prev_sat);
      end
      hold_prev = SUM_VALID && !SUM_READY;
      prev_sum  = SUM_OUT;
      prev_sat  = SAT;
      if (m_active && m_k == NW) dcnt++;
      hs = X_VALID && X_READY && (m_k < NW);
      if (hs) begin
        m_acc += longint'($signed(mem[m_k])) * longint'($signed(X_DATA));
        m_k++;
        if (m_k == NW) dcnt = 0;
      end
      prev_hs = hs;
      ps = 0;
      if (START && !m_active) begin
        m_active = 1; m_k = 0; m_acc = 0; dcnt = 0; start_cyc = cyc; ps = 1;
        for (int a = 0; a < 32; a++) reads[a] = 0;
      end else if (SUM_VALID && SUM_READY) begin
        m_active = 0; dcnt = 0;
        res_sum = SUM_OUT; res_sat = SAT;
        model_result(m_acc, mres_sum, mres_sat);
        n_results++;
      end
      prev_start = ps;
    end
  end

  task automatic load(input bit ramp, input logic [15:0] c);
    for (int i = 0; i < 32; i++) mem[i] = ramp ? 16'(i) * c : c;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_x_ready"}, X_READY, 0);
    chk({tag, "_bram_addr"}, BRAM_ADDR, 0);
    chk({tag, "_bram_en"}, BRAM_EN, 0);
    chk({tag, "_sum_out"}, SUM_OUT, 0);
    chk({tag, "_sum_valid"}, SUM_VALID, 0);
    chk({tag, "_sat"}, SAT, 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  task automatic run_neuron(input logic [15:0] xv, input int gap_max, input int hold,
                            input bit start_mid, input bit start_hs, input int abort_at);
    int sent, gap_left, to, r0;
    bit mid_done;
    r0 = n_results; sent = 0; gap_left = 0; to = 0; mid_done = 0;
    X_DATA = xv;
    @(negedge CLK); #1; START = 1;
    @(negedge CLK); #1; START = 0;
    while (sent < NW && to < 2000) begin
      if (gap_left > 0) begin X_VALID = 0; gap_left--; end
      else X_VALID = 1;
      START = start_mid && !mid_done && sent == 10;
      if (START) mid_done = 1;
      #2;
      if (X_VALID && X_READY) begin
        sent++;
        gap_left = $urandom_range(0, gap_max);
      end
      to++;
      if (abort_at > 0 && sent == abort_at) break;
      @(negedge CLK); #1;
    end
    chk("x_stream_timeout", to < 2000, 1);
    @(negedge CLK); #1; X_VALID = 0; START = 0;
    if (abort_at > 0) return;
    #2;
    to = 0;
    while (!SUM_VALID && to < 200) begin @(negedge CLK); #3; to++; end
    chk("sum_valid_timeout", to < 200, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK); #1; START = (i == 3);
    end
    @(negedge CLK); #1; SUM_READY = 1; START = start_hs;
    @(negedge CLK); #1; SUM_READY = 0; START = 0;
    chk("result_count", n_results, r0 + 1);
    repeat (2) @(negedge CLK);
    #3;
    chk("idle_busy", BUSY, 0);
    chk("idle_sum_valid", SUM_VALID, 0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] s, input logic st);
    chk({tag, "_dut_sum"}, res_sum, s);
    chk({tag, "_dut_sat"}, res_sat, st);
    chk({tag, "_model_sum"}, mres_sum, s);
    chk({tag, "_model_sat"}, mres_sat, st);
  endtask

  initial begin
    RST_N = 0; START = 0; X_VALID = 0; X_DATA = 0; SUM_READY = 0;
    load(0, 16'h0100);
    #3;
    check_idle_outputs("rst");
    @(posedge CLK); #3; RST_N = 1;
    repeat (2) @(negedge CLK);

    // 30 x (1.0 * 1.0) = 30.0
    run_neuron(16'h0100, 0, 0, 0, 0, 0);
    check_result("s1", 16'h1E00, 1'b0);
    chk("s1_latency", lat, 32);
    for (int a = 0; a < NW; a++) chk($sformatf("s1_reads_%0d", a), reads[a], 1);

    // -0.5 * (0+1+..+29) = -217.5 lies below the Q8.8 range, so the result clips
    load(1, 16'h0100);
    run_neuron(16'hFF80, 5, 0, 0, 0, 0);
    check_result("s2", 16'h8000, 1'b1);

    // -0.5 * 435/16 = -13.59375, with a START pulse mid-run
    load(1, 16'h0010);
    run_neuron(16'hFF80, 3, 0, 1, 0, 0);
    check_result("s3", 16'hF268, 1'b0);

    // positive clip, 10 cycles of back-pressure, START in the handshake cycle
    load(0, 16'h7FFF);
    run_neuron(16'h7FFF, 0, 10, 0, 1, 0);
    check_result("s4", 16'h7FFF, 1'b1);

    // negative clip
    load(0, 16'h8000);
    run_neuron(16'h7FFF, 2, 0, 0, 0, 0);
    check_result("s5", 16'h8000, 1'b1);

    // 30 x (-1/65536): floor toward -inf gives -1 LSB
    load(0, 16'h0001);
    run_neuron(16'hFFFF, 1, 0, 0, 0, 0);
    check_result("s6", 16'hFFFF, 1'b0);

    // abort after 12 accepts, then a clean rerun
    load(0, 16'h0100);
    run_neuron(16'h0100, 0, 0, 0, 0, 12);
    chk("abort_accepts", m_k, 12);
    @(posedge CLK); #3; RST_N = 0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(posedge CLK);
    #3; RST_N = 1;
    repeat (2) @(negedge CLK);
    run_neuron(16'h0100, 0, 0, 0, 0, 0);
    check_result("s7", 16'h1E00, 1'b0);
    chk("s7_latency", lat, 32);
    chk("results_total", n_results, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
